// File: rtl/qos_pkg.sv
// Shared definitions for the QoS class FIFO datapath.
// Holds the class count, word width, per-class counter width and saturation
// value, the 2-bit class index type, and a small wrap-around helper.
package qos_pkg;

    localparam int unsigned NCLASS = 4;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CLS_W  = 2;

    typedef logic [CLS_W-1:0] cls_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_SAT = '1;

    // Next class in ascending round-robin order, wrapping 3 -> 0.
    function automatic cls_idx_t next_cls(input cls_idx_t c);
        return c + cls_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// Ports:
//   req_i   [3:0] request vector
//   ptr_i   [1:0] class the search starts from (ascending, wrapping)
//   grant_o [3:0] one-hot grant, zero when no request
//   idx_o   [1:0] encoded granted class (ptr_i when nothing granted)
//   any_o         a grant was issued
module rr_arbiter4
    import qos_pkg::*;
(
    input  logic [NCLASS-1:0] req_i,
    input  cls_idx_t          ptr_i,
    output logic [NCLASS-1:0] grant_o,
    output cls_idx_t          idx_o,
    output logic              any_o
);

    cls_idx_t cand;

    // Rotate the search window to start at ptr_i; first requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = ptr_i;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int k = 0; k < int'(NCLASS); k++) begin
            cand = ptr_i + cls_idx_t'(k);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/qos_rr_drain.sv
// Drains four per-class QoS FIFOs into one egress stream using
// work-conserving round robin, one word per cycle, and keeps saturating
// per-class forwarded-word counters readable through a req/idx port.
// Ports:
//   clk, reset            clock, async active-high reset
//   init                  sync clear of counters and RR pointer, blocks pops
//   active                0 inhibits all pops
//   fifo_empty[3:0]       class FIFO empty flags
//   fifo_dataout0..3      class FIFO read data, valid the cycle after pop
//   almost_full           egress backpressure, 1 inhibits new pops
//   pop[3:0]              one-hot class FIFO pop (combinational)
//   data_out, push_out    egress word and its push strobe
//   req, idx[2:0]         counter read request / index
//   valid, data           counter read response, one cycle after req
module qos_rr_drain
    import qos_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              active,
    input  logic [NCLASS-1:0] fifo_empty,
    input  logic [DATA_W-1:0] fifo_dataout0,
    input  logic [DATA_W-1:0] fifo_dataout1,
    input  logic [DATA_W-1:0] fifo_dataout2,
    input  logic [DATA_W-1:0] fifo_dataout3,
    input  logic              almost_full,
    output logic [NCLASS-1:0] pop,
    output logic [DATA_W-1:0] data_out,
    output logic              push_out,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic              valid,
    output logic [CNT_W-1:0]  data
);

    cls_idx_t          rr_ptr_q, rr_ptr_d;
    cls_idx_t          grant_q, grant_d;
    logic              push_pend_q, push_pend_d;
    logic [DATA_W-1:0] last_q, last_d;
    cnt_t              cnt_q [NCLASS];
    cnt_t              cnt_d [NCLASS];
    logic              valid_q, valid_d;
    cnt_t              data_q, data_d;

    logic [NCLASS-1:0] eligible_c;
    logic [NCLASS-1:0] grant_c;
    cls_idx_t          gidx_c;
    logic              gany_c;
    logic [DATA_W-1:0] dsel_c;

    // A class may be popped only when it has data and nothing is holding us off.
    assign eligible_c = ~fifo_empty & {NCLASS{active & ~almost_full & ~init}};

    rr_arbiter4 u_arb (
        .req_i   (eligible_c),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_c),
        .idx_o   (gidx_c),
        .any_o   (gany_c)
    );

    assign pop = grant_c;

    // Registered select picks the FIFO that was popped last cycle.
    always_comb begin
        dsel_c = fifo_dataout0;
        case (grant_q)
            2'd0:    dsel_c = fifo_dataout0;
            2'd1:    dsel_c = fifo_dataout1;
            2'd2:    dsel_c = fifo_dataout2;
            default: dsel_c = fifo_dataout3;
        endcase
    end

    // data_out holds the last pushed word while no push is in progress.
    assign push_out = push_pend_q;
    assign data_out = push_pend_q ? dsel_c : last_q;
    assign valid    = valid_q;
    assign data     = data_q;

    // Next-state: arbitration pointer, egress pipe, counters, read port.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        push_pend_d = 1'b0;
        last_d      = last_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        for (int i = 0; i < int'(NCLASS); i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (gany_c) begin
            rr_ptr_d    = next_cls(gidx_c);
            grant_d     = gidx_c;
            push_pend_d = 1'b1;
        end

        if (push_pend_q) begin
            last_d = dsel_c;
        end

        // init wins over a coinciding push: that word goes out uncounted.
        if (init) begin
            rr_ptr_d = '0;
            for (int i = 0; i < int'(NCLASS); i++) begin
                cnt_d[i] = '0;
            end
        end else if (push_pend_q && (cnt_q[grant_q] != CNT_SAT)) begin
            cnt_d[grant_q] = cnt_q[grant_q] + cnt_t'(1);
        end

        // Read returns the pre-update count; out-of-range index answers zero.
        if (req) begin
            if (!idx[2]) begin
                valid_d = 1'b1;
                data_d  = cnt_q[idx[1:0]];
            end else begin
                data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            push_pend_q <= 1'b0;
            last_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            for (int i = 0; i < int'(NCLASS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            push_pend_q <= push_pend_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            for (int i = 0; i < int'(NCLASS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_qos_rr_drain.sv
// Directed bench for qos_rr_drain with behavioural class FIFOs and an
// egress scoreboard of expected words in push order.
module tb_qos_rr_drain;
    import qos_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              active;
    logic [3:0]        fifo_empty = 4'hF;
    logic [11:0]       fdo [4];
    logic              almost_full;
    logic [3:0]        pop;
    logic [11:0]       data_out;
    logic              push_out;
    logic              req;
    logic [2:0]        idx;
    logic              valid;
    logic [4:0]        data;

    logic              ld_v;
    logic [1:0]        ld_cls;
    logic [11:0]       ld_word;
    logic [11:0]       fq [4][$];
    logic [11:0]       sb [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qos_rr_drain dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .active        (active),
        .fifo_empty    (fifo_empty),
        .fifo_dataout0 (fdo[0]),
        .fifo_dataout1 (fdo[1]),
        .fifo_dataout2 (fdo[2]),
        .fifo_dataout3 (fdo[3]),
        .almost_full   (almost_full),
        .pop           (pop),
        .data_out      (data_out),
        .push_out      (push_out),
        .req           (req),
        .idx           (idx),
        .valid         (valid),
        .data          (data)
    );

    // Class FIFO model: read data valid the cycle after pop, empty updates at the same edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && fq[i].size() > 0) fdo[i] <= fq[i].pop_front();
        end
        if (ld_v) fq[ld_cls].push_back(ld_word);
        for (int i = 0; i < 4; i++) fifo_empty[i] <= (fq[i].size() == 0);
    end

    initial begin
        for (int i = 0; i < 4; i++) fdo[i] = '0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Egress monitor: every push must match the head of the scoreboard.
    task automatic mon();
        if (push_out === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_push observed=%0h expected=no_push", data_out);
            end
            if (sb.size() != 0) chk("egress_data", 32'(data_out), 32'(sb.pop_front()));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic ckpop(input string tag, input logic [3:0] e);
        #1;
        chk(tag, 32'(pop), 32'(e));
    endtask

    task automatic load(input logic [1:0] c, input logic [11:0] w);
        ld_v = 1'b1; ld_cls = c; ld_word = w;
        cyc();
        ld_v = 1'b0;
    endtask

    task automatic rd(input logic [2:0] i, input logic exp_v, input logic [4:0] exp_d);
        req = 1'b1; idx = i;
        cyc();
        req = 1'b0;
        chk("rd_valid", 32'(valid), 32'(exp_v));
        chk("rd_data", 32'(data), 32'(exp_d));
    endtask

    task automatic pulse_init();
        init = 1'b1;
        cyc();
        init = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        cyc();
        cyc();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; active = 1'b1; almost_full = 1'b0;
        req = 1'b0; idx = '0; ld_v = 1'b0; ld_cls = '0; ld_word = '0;

        // Reset values and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            chk("idle_pop", 32'(pop), 32'd0);
            chk("idle_push", 32'(push_out), 32'd0);
        end
        rd(3'd2, 1'b1, 5'd0);

        // Round robin over four single-word FIFOs
        active = 1'b0;
        load(2'd0, 12'h37D); load(2'd1, 12'hF04); load(2'd2, 12'hE95); load(2'd3, 12'hAAE);
        sb.push_back(12'h37D); sb.push_back(12'hF04); sb.push_back(12'hE95); sb.push_back(12'hAAE);
        active = 1'b1;
        ckpop("rr_pop0", 4'b0001); cyc();
        ckpop("rr_pop1", 4'b0010); cyc();
        ckpop("rr_pop2", 4'b0100); cyc();
        ckpop("rr_pop3", 4'b1000); cyc();
        ckpop("rr_pop_done", 4'b0000);
        drain_check("rr_drained");

        // Skip empty classes, fairness between 1 and 3
        active = 1'b0;
        pulse_init();
        for (int k = 1; k <= 3; k++) begin
            load(2'd1, 12'(12'h100 + k));
            load(2'd3, 12'(12'h300 + k));
        end
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(12'(12'h100 + k));
            sb.push_back(12'(12'h300 + k));
        end
        active = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ckpop("skip_pop1", 4'b0010); cyc();
            ckpop("skip_pop3", 4'b1000); cyc();
        end
        ckpop("skip_done", 4'b0000);
        drain_check("skip_drained");
        rd(3'd0, 1'b1, 5'd0);
        rd(3'd1, 1'b1, 5'd3);
        rd(3'd2, 1'b1, 5'd0);
        rd(3'd3, 1'b1, 5'd3);

        // Backpressure mid-stream, one trailing push, pointer resumes after last grant
        active = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            load(2'd0, 12'(12'hA00 + k));
            load(2'd2, 12'(12'hC00 + k));
        end
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(12'(12'hA00 + k));
            sb.push_back(12'(12'hC00 + k));
        end
        active = 1'b1;
        ckpop("bp_pop_a", 4'b0001); cyc();
        ckpop("bp_pop_c", 4'b0100); cyc();
        almost_full = 1'b1;
        ckpop("bp_af_pop", 4'b0000);
        chk("bp_trailing_push", 32'(push_out), 32'd1);
        for (int n = 0; n < 3; n++) begin
            cyc();
            ckpop("bp_af_pop", 4'b0000);
            chk("bp_af_nopush", 32'(push_out), 32'd0);
        end
        cyc();
        almost_full = 1'b0;
        ckpop("bp_resume_0", 4'b0001); cyc();
        ckpop("bp_resume_2", 4'b0100); cyc();
        ckpop("bp_resume_0b", 4'b0001); cyc();
        ckpop("bp_resume_2b", 4'b0100); cyc();
        ckpop("bp_done", 4'b0000);
        drain_check("bp_drained");

        // active low blocks pops; then init clears counters and pointer
        active = 1'b0;
        load(2'd1, 12'h1A1); load(2'd1, 12'h1A2);
        sb.push_back(12'h1A1); sb.push_back(12'h1A2);
        for (int n = 0; n < 3; n++) begin
            ckpop("inactive_pop", 4'b0000); cyc();
        end
        active = 1'b1;
        ckpop("act_pop1", 4'b0010); cyc();
        ckpop("act_pop1b", 4'b0010); cyc();
        drain_check("act_drained");
        rd(3'd1, 1'b1, 5'd5);
        pulse_init();
        for (int i = 0; i < 4; i++) rd(3'(i), 1'b1, 5'd0);
        active = 1'b0;
        load(2'd2, 12'h2B0); load(2'd0, 12'h0B0);
        sb.push_back(12'h0B0); sb.push_back(12'h2B0);
        active = 1'b1;
        ckpop("init_first_0", 4'b0001); cyc();
        ckpop("init_then_2", 4'b0100); cyc();
        drain_check("init_drained");

        // Saturation through class 2, back-to-back pops
        active = 1'b0;
        pulse_init();
        for (int k = 0; k < 40; k++) begin
            load(2'd2, 12'(12'h200 + k));
            sb.push_back(12'(12'h200 + k));
        end
        active = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ckpop("sat_pop", 4'b0100); cyc();
        end
        ckpop("sat_done", 4'b0000);
        drain_check("sat_drained");
        rd(3'd2, 1'b1, 5'd31);
        rd(3'd5, 1'b0, 5'd0);

        // Read colliding with a push returns the pre-increment count
        active = 1'b0;
        pulse_init();
        for (int k = 0; k < 5; k++) begin
            load(2'd0, 12'(12'h050 + k));
            sb.push_back(12'(12'h050 + k));
        end
        active = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ckpop("col_pop", 4'b0001); cyc();
        end
        drain_check("col_drained");
        rd(3'd0, 1'b1, 5'd5);
        active = 1'b0;
        load(2'd0, 12'h0FF);
        sb.push_back(12'h0FF);
        active = 1'b1;
        ckpop("col_pop_last", 4'b0001); cyc();
        req = 1'b1; idx = 3'd0;
        #1;
        chk("col_push_now", 32'(push_out), 32'd1);
        cyc();
        req = 1'b0;
        chk("col_valid", 32'(valid), 32'd1);
        chk("col_pre_inc", 32'(data), 32'd5);
        cyc();
        chk("hold_valid", 32'(valid), 32'd0);
        chk("hold_data", 32'(data), 32'd5);
        rd(3'd0, 1'b1, 5'd6);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
